// File: rtl/nes_pkg.sv
// Shared NES core definitions: CPU ALU modes, sprite DMA state encoding, bus ownership
// and the memory-mapped register addresses the DMA block decodes.
package nes_pkg;

  typedef enum logic [3:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluEor,
    AluAsl,
    AluLsr,
    AluRol,
    AluRor,
    AluPass
  } alu_mode_t;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StHalt,
    StAlign,
    StRead,
    StWrite
  } dma_state_t;

  // Who drives the system bus this cycle; CpuNoWr is the CPU's stalled repeat read.
  typedef enum logic [1:0] {
    OwnCpu,
    OwnCpuNoWr,
    OwnDmaRd,
    OwnDmaWr
  } bus_owner_t;

  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

  function automatic logic dma_stalls_cpu(dma_state_t s);
    return s inside {StHalt, StAlign, StRead, StWrite};
  endfunction

endpackage

// File: rtl/bus_mux.sv
// Combinational system-bus owner select between the 6502 and the sprite DMA engine.
module bus_mux
  import nes_pkg::*;
(
  input  bus_owner_t  owner_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [7:0]  cpu_d_out_i,
  input  logic        cpu_write_i,
  input  logic [15:0] dma_rd_addr_i,
  input  logic [15:0] dma_wr_addr_i,
  input  logic [7:0]  dma_d_out_i,
  output logic [15:0] bus_addr_o,
  output logic [7:0]  bus_d_out_o,
  output logic        bus_write_o
);

  always_comb begin
    bus_addr_o  = cpu_addr_i;
    bus_d_out_o = cpu_d_out_i;
    bus_write_o = cpu_write_i;
    unique case (owner_i)
      OwnCpu: begin
      end
      OwnCpuNoWr: begin
        bus_write_o = 1'b0;
      end
      OwnDmaRd: begin
        bus_addr_o  = dma_rd_addr_i;
        bus_d_out_o = dma_d_out_i;
        bus_write_o = 1'b0;
      end
      OwnDmaWr: begin
        bus_addr_o  = dma_wr_addr_i;
        bus_d_out_o = dma_d_out_i;
        bus_write_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA controller: a CPU write to the DMA register latches a source page, then the
// 6502 is stalled while XFER_LEN bytes are copied from that page to the OAM data port.
module oam_dma_ctrl
  import nes_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = ADDR_OAMDMA,
  parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA,
  parameter int unsigned XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_write,
  output logic        cpu_ready,
  input  logic [7:0]  bus_d_in,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_d_out,
  output logic        bus_write,
  output logic        busy
);

  localparam logic [7:0] LastIdx = 8'(XFER_LEN - 1);

  dma_state_t state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] latch_q, latch_d;
  logic       par_q, par_d;
  logic       trigger;
  bus_owner_t owner;

  assign trigger = cpu_write && (cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      latch_q <= 8'h00;
      par_q   <= 1'b0;
    end else begin
      page_q  <= page_d;
      idx_q   <= idx_d;
      latch_q <= latch_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d = StArmed;
        end
      end
      StArmed: begin
        // The 6502 only honours ready on a read, so wait for one before halting.
        if (!trigger && !cpu_write) begin
          state_d = StHalt;
        end
      end
      StHalt: begin
        state_d = par_q ? StRead : StAlign;
      end
      StAlign: begin
        state_d = StRead;
      end
      StRead: begin
        state_d = StWrite;
      end
      StWrite: begin
        state_d = (idx_q == LastIdx) ? StIdle : StRead;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    page_d  = page_q;
    idx_d   = idx_q;
    latch_d = latch_q;
    par_d   = ~par_q;
    if ((state_q == StIdle || state_q == StArmed) && trigger) begin
      page_d = cpu_d_out;
    end
    if (state_q == StRead) begin
      latch_d = bus_d_in;
    end
    if (state_q == StWrite) begin
      idx_d = (idx_q == LastIdx) ? 8'h00 : idx_q + 8'd1;
    end
  end

  always_comb begin
    cpu_ready = !dma_stalls_cpu(state_q);
    busy      = (state_q != StIdle);
    owner     = OwnCpu;
    unique case (state_q)
      StIdle, StArmed: owner = OwnCpu;
      StHalt, StAlign: owner = OwnCpuNoWr;
      StRead:          owner = OwnDmaRd;
      StWrite:         owner = OwnDmaWr;
      default:         owner = OwnCpu;
    endcase
  end

  bus_mux u_bus_mux (
    .owner_i       (owner),
    .cpu_addr_i    (cpu_addr),
    .cpu_d_out_i   (cpu_d_out),
    .cpu_write_i   (cpu_write),
    .dma_rd_addr_i ({page_q, idx_q}),
    .dma_wr_addr_i (OAM_DATA_ADDR),
    .dma_d_out_i   (latch_q),
    .bus_addr_o    (bus_addr),
    .bus_d_out_o   (bus_d_out),
    .bus_write_o   (bus_write)
  );

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: a cycle-scheduled transfer model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_oam_dma_ctrl;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_write;
  logic        cpu_ready;
  logic [7:0]  bus_d_in;
  logic [15:0] bus_addr;
  logic [7:0]  bus_d_out;
  logic        bus_write;
  logic        busy;

  logic [7:0] mem [0:65535];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: cycles counted from reset release, transfer described by start and length.
  int unsigned cyc      = 0;
  bit          m_armed  = 0;
  bit          m_active = 0;
  logic [7:0]  m_page   = 8'h00;
  int unsigned m_start  = 0;
  int unsigned m_len    = 0;

  // Observations gathered by the compare process.
  int          dma_wr_cnt = 0;
  logic [7:0]  first_data, last_data;
  logic [15:0] first_src, last_src, prev_addr;
  int          run = 0;
  int          last_stall = 0;

  oam_dma_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_d_out (cpu_d_out),
    .cpu_write (cpu_write),
    .cpu_ready (cpu_ready),
    .bus_d_in  (bus_d_in),
    .bus_addr  (bus_addr),
    .bus_d_out (bus_d_out),
    .bus_write (bus_write),
    .busy      (busy)
  );

  assign bus_d_in = mem[bus_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_step();
    int unsigned k;
    k = cyc;
    if (m_active) begin
      if (k == m_start + m_len - 1) m_active = 0;
    end else if (cpu_write && cpu_addr == 16'h4014) begin
      m_armed = 1;
      m_page  = cpu_d_out;
    end else if (m_armed && !cpu_write) begin
      m_armed  = 0;
      m_active = 1;
      m_start  = k + 1;
      m_len    = ((k + 1) % 2 == 0) ? 514 : 513;
    end
    cyc = k + 1;
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_active = 0;
      m_armed  = 0;
      cyc      = 0;
    end else begin
      model_step();
    end
  end

  // Compare process: samples 3 time units after the falling edge.
  initial forever begin
    logic        e_ready, e_busy, e_wr, e_chk_d;
    logic [15:0] e_addr;
    logic [7:0]  e_dout;
    int unsigned off, pre, j;
    logic [7:0]  bi;
    @(negedge clk);
    #3;
    e_ready = 1'b1;
    e_busy  = m_armed;
    e_addr  = cpu_addr;
    e_dout  = cpu_d_out;
    e_wr    = cpu_write;
    e_chk_d = 1'b1;
    if (m_active) begin
      e_ready = 1'b0;
      e_busy  = 1'b1;
      off     = cyc - m_start;
      pre     = m_len - 512;
      if (off < pre) begin
        e_wr = 1'b0;
      end else begin
        j  = off - pre;
        bi = 8'(j / 2);
        if (j % 2 == 0) begin
          e_addr  = {m_page, bi};
          e_wr    = 1'b0;
          e_chk_d = 1'b0;
        end else begin
          e_addr = 16'h2004;
          e_dout = mem[{m_page, bi}];
          e_wr   = 1'b1;
        end
      end
    end
    chk("cyc_ready", 32'(cpu_ready), 32'(e_ready));
    chk("cyc_busy", 32'(busy), 32'(e_busy));
    chk("cyc_bus_addr", 32'(bus_addr), 32'(e_addr));
    chk("cyc_bus_write", 32'(bus_write), 32'(e_wr));
    if (e_chk_d) chk("cyc_bus_d_out", 32'(bus_d_out), 32'(e_dout));
    if (bus_write === 1'b1 && bus_addr == 16'h2004 && cpu_ready === 1'b0) begin
      if (dma_wr_cnt == 0) begin
        first_data = bus_d_out;
        first_src  = prev_addr;
      end
      last_data = bus_d_out;
      last_src  = prev_addr;
      dma_wr_cnt++;
    end
    prev_addr = bus_addr;
    if (cpu_ready === 1'b0) begin
      run++;
    end else if (run > 0) begin
      last_stall = run;
      run        = 0;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic cpu_cyc(input logic [15:0] a, input logic [7:0] d, input logic w);
    @(negedge clk);
    cpu_addr  = a;
    cpu_d_out = d;
    cpu_write = w;
  endtask

  task automatic clear_stats();
    dma_wr_cnt = 0;
    last_stall = 0;
    run        = 0;
  endtask

  // Next driven cycle will have parity p.
  task automatic align_next(input int p);
    while ((cyc + 1) % 2 != p) cpu_cyc(16'h8000, 8'h00, 1'b0);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (cpu_ready !== 1'b0 && n < 8) begin
      cpu_cyc(16'h8000, 8'h00, 1'b0);
      #3;
      n++;
    end
    while (cpu_ready !== 1'b1 && n < 700) begin
      cpu_cyc(16'h8000, 8'h00, 1'b0);
      #3;
      n++;
    end
    chk({name, "_done"}, 32'(cpu_ready), 1);
    cpu_cyc(16'h8000, 8'h00, 1'b0);
    #4;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      logic [15:0] ad;
      ad = 16'(a);
      mem[ad] = (ad[15:8] == 8'h02) ? (ad[7:0] ^ 8'h5A) : (ad[7:0] ^ ad[15:8] ^ 8'hC3);
    end
    reset     = 1'b0;
    cpu_addr  = 16'h8000;
    cpu_d_out = 8'h00;
    cpu_write = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(cpu_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bus_addr", 32'(bus_addr), 'h8000);
    @(negedge clk);
    reset = 1'b1;

    // Pass-through with no trigger
    cpu_cyc(16'h4015, 8'h33, 1'b1);
    #3;
    chk("pt_addr", 32'(bus_addr), 'h4015);
    chk("pt_write", 32'(bus_write), 1);
    chk("pt_d_out", 32'(bus_d_out), 'h33);
    cpu_cyc(16'h2004, 8'h44, 1'b1);
    #3;
    chk("pt_busy", 32'(busy), 0);
    chk("pt_ready", 32'(cpu_ready), 1);
    cpu_cyc(16'h2004, 8'h00, 1'b0);
    cpu_cyc(16'h4015, 8'h00, 1'b0);

    // Basic copy with HALT on an even cycle: ALIGN inserted
    align_next(0);
    clear_stats();
    cpu_cyc(16'h4014, 8'h02, 1'b1);
    cpu_cyc(16'h8000, 8'h00, 1'b0);
    wait_done("basic");
    chk("basic_count", 32'(dma_wr_cnt), 256);
    chk("basic_first_data", 32'(first_data), 'h5A);
    chk("basic_last_data", 32'(last_data), 'hA5);
    chk("basic_first_src", 32'(first_src), 'h0200);
    chk("basic_last_src", 32'(last_src), 'h02FF);
    chk("basic_stall", 32'(last_stall), 514);

    // HALT on an odd cycle: no ALIGN
    align_next(1);
    clear_stats();
    cpu_cyc(16'h4014, 8'h03, 1'b1);
    cpu_cyc(16'h8000, 8'h00, 1'b0);
    wait_done("odd");
    chk("odd_stall", 32'(last_stall), 513);
    chk("odd_count", 32'(dma_wr_cnt), 256);
    chk("odd_first_data", 32'(first_data), 'hC0);

    // Deferred halt: two CPU writes follow the trigger
    clear_stats();
    cpu_cyc(16'h4014, 8'h05, 1'b1);
    cpu_cyc(16'h0100, 8'hAA, 1'b1);
    #3;
    chk("defer_ready1", 32'(cpu_ready), 1);
    chk("defer_busy1", 32'(busy), 1);
    chk("defer_addr1", 32'(bus_addr), 'h0100);
    chk("defer_write1", 32'(bus_write), 1);
    cpu_cyc(16'h01FF, 8'hBB, 1'b1);
    #3;
    chk("defer_ready2", 32'(cpu_ready), 1);
    chk("defer_addr2", 32'(bus_addr), 'h01FF);
    chk("defer_write2", 32'(bus_write), 1);
    cpu_cyc(16'h8000, 8'h00, 1'b0);
    #3;
    chk("defer_ready_read", 32'(cpu_ready), 1);
    cpu_cyc(16'h8000, 8'h00, 1'b0);
    #3;
    chk("defer_halt", 32'(cpu_ready), 0);
    wait_done("defer");
    chk("defer_count", 32'(dma_wr_cnt), 256);
    chk("defer_first_src", 32'(first_src), 'h0500);

    // Retrigger while armed, then $4014 writes during the stall are ignored
    clear_stats();
    cpu_cyc(16'h4014, 8'h03, 1'b1);
    cpu_cyc(16'h4014, 8'h07, 1'b1);
    cpu_cyc(16'h8000, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) cpu_cyc(16'h4014, 8'h09, 1'b1);
    wait_done("retrig");
    chk("retrig_count", 32'(dma_wr_cnt), 256);
    chk("retrig_first_src", 32'(first_src), 'h0700);
    chk("retrig_last_src", 32'(last_src), 'h07FF);
    chk("retrig_first_data", 32'(first_data), 'hC4);
    chk("retrig_idle_busy", 32'(busy), 0);

    // Reset mid-transfer after 100 DMA writes
    clear_stats();
    cpu_cyc(16'h4014, 8'h04, 1'b1);
    begin
      int n;
      n = 0;
      while (dma_wr_cnt < 100 && n < 400) begin
        cpu_cyc(16'h8000, 8'h00, 1'b0);
        #4;
        n++;
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_write", 32'(bus_write), 0);
    chk("mid_rst_ready", 32'(cpu_ready), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) cpu_cyc(16'h8000, 8'h00, 1'b0);
    #4;
    chk("mid_rst_count", 32'(dma_wr_cnt), 100);
    chk("mid_rst_last_src", 32'(last_src), 'h0463);

    // Fresh full copy from the top page
    clear_stats();
    cpu_cyc(16'h4014, 8'hFF, 1'b1);
    cpu_cyc(16'h8000, 8'h00, 1'b0);
    wait_done("topage");
    chk("top_count", 32'(dma_wr_cnt), 256);
    chk("top_first_src", 32'(first_src), 'hFF00);
    chk("top_last_src", 32'(last_src), 'hFFFF);
    chk("top_last_data", 32'(last_data), 'hC3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sprite DMA controller and bus arbiter between the 6502 core and the system bus.
- A CPU write to $4014 latches a source page. The block then stalls the CPU via its ready input and copies 256 bytes from {page,8'h00..8'hFF} to the PPU OAM data port $2004.
- It owns the bus while copying and passes the CPU's bus through transparently at all other times.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers a transfer
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write
- XFER_LEN, 256, bytes per transfer; 8-bit index, final index XFER_LEN-1

Ports:
- clk  in  1  system clock; all state on posedge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- cpu_addr  in  16  CPU address output
- cpu_d_out  in  8  CPU write data
- cpu_write  in  1  CPU write strobe (1 = write cycle)
- cpu_ready  out  1  to CPU ready; 0 stalls the CPU
- bus_d_in  in  8  read data returned from memory/bus
- bus_addr  out  16  arbitrated bus address
- bus_d_out  out  8  arbitrated bus write data
- bus_write  out  1  arbitrated bus write strobe
- busy  out  1  1 while a transfer is pending or in progress

Behaviour:
- States: IDLE, ARMED, HALT, ALIGN, READ, WRITE. All outputs are Moore or a combinational mux of registered state.
- Reset (async, reset=0):
  - state=IDLE, page=0, idx=0, latch=0, par=0.
  - Resulting outputs: cpu_ready=1, busy=0, bus is CPU pass-through.
- par: a 1-bit toggle that flips every clk from reset. A cycle is "even" when par==0.
- Trigger: in IDLE or ARMED, cpu_write=1 and cpu_addr==DMA_REG_ADDR sampled at posedge → page<=cpu_d_out, state<=ARMED.
  - A second trigger while in ARMED overwrites page.
- ARMED: cpu_ready=1. The first posedge with cpu_write=0 → HALT. The 6502 honours ready only on read cycles.
- HALT: one dummy cycle, cpu_ready=0.
  - par==1 in HALT → READ next.
  - par==0 in HALT → ALIGN next.
- ALIGN: one dummy cycle, cpu_ready=0 → READ.
- READ: always occurs on an even cycle. bus_addr={page,idx}, bus_write=0; latch<=bus_d_in at posedge → WRITE.
- WRITE: bus_addr=OAM_DATA_ADDR, bus_d_out=latch, bus_write=1.
  - idx==XFER_LEN-1 → idx<=0, state<=IDLE.
  - Otherwise idx<=idx+1, state<=READ.
- Bus mux:
  - IDLE/ARMED: bus_* = cpu_* (pass-through).
  - HALT/ALIGN: bus_addr=cpu_addr, bus_d_out=cpu_d_out, bus_write forced 0. The CPU's repeated read is harmless.
- cpu_ready=0 exactly in HALT, ALIGN, READ, WRITE. busy=1 in every state except IDLE.
- Stall length: 513 cycles (no ALIGN) or 514 cycles (with ALIGN). cpu_ready returns to 1 on the cycle after the final WRITE.
- Boundaries:
  - CPU addresses $4014 during HALT..WRITE: ignored; the CPU is stalled and no retrigger is possible.
  - idx wraps 8'hFF→8'h00 only at transfer end.
  - page=8'hFF sources $FF00-$FFFF with no special case.
  - Reset asserted mid-transfer aborts immediately to the reset state. No further bus writes occur and cpu_ready=1 once reset is released.
- Counts of bus_write=1 cycles during a transfer: exactly XFER_LEN, all to OAM_DATA_ADDR.

Decomposition:
- Shared package nes_pkg:
  - dma_state_t enum (IDLE, ARMED, HALT, ALIGN, READ, WRITE).
  - Address constants ADDR_OAMDMA=16'h4014, ADDR_OAMDATA=16'h2004.
  - Alongside the existing ALU mode constants.
- One natural sub-module: bus_mux (combinational owner select of addr/d_out/write). The FSM, counter and parity stay in oam_dma_ctrl.

Test Plan:
- Basic copy:
  - Stimulus: memory $0200+i = i^8'h5A; CPU writes 8'h02 to $4014; next CPU cycle is a read.
  - Response: 256 writes to $2004 with data 8'h5A, 8'h5B, ... 8'hA5; source addresses $0200-$02FF in order; cpu_ready low for 513 or 514 cycles matching par.
- Alignment:
  - Stimulus: trigger so that HALT lands on par==0, then repeat with HALT on par==1.
  - Response: stall length 514 then 513; every READ on par==0.
- Deferred halt:
  - Stimulus: the $4014 write is followed by two more CPU write cycles (e.g. to $0100, $01FF), then a read.
  - Response: cpu_ready stays 1 through both writes; both appear on bus_write; HALT begins after the read.
- Retrigger in ARMED:
  - Stimulus: write 8'h03 then 8'h07 to $4014 back-to-back.
  - Response: transfer sources $0700-$07FF only.
- Reset mid-transfer:
  - Stimulus: reset=0 asserted asynchronously after 100 DMA writes, released 3 cycles later.
  - Response: bus_write=0 and cpu_ready=1 immediately; busy=0; no further $2004 writes; a new trigger then does a full 256-byte copy.
- Pass-through:
  - Stimulus: CPU accesses $4015 and $2004 with no trigger.
  - Response: bus_* equals cpu_* every cycle; cpu_ready=1 and busy=0 throughout.
